// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg -- shared types and encodings for the RV32I multi-cycle controller.
//   state_e  : controller FSM states (value is exported on state_o for debug)
//   iclass_e : instruction class decoded from the 7-bit opcode
//   OP_*     : RV32I base opcodes recognised by the controller
//   PC_*/A_*/B_*/ALU_*/WB_* : datapath mux / ALU-op encodings
//   ctrl_t   : bundle of every per-cycle datapath control the FSM drives
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_R, CLS_I, CLS_LOAD, CLS_STORE,
    CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI, CLS_AUIPC
  } iclass_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JAL    = 2'd2;
  localparam logic [1:0] PC_JALR   = 2'd3;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if -- shared instruction/data memory handshake.
//   mem_req   : controller -> memory, request held until mem_ready
//   mem_we    : controller -> memory, write (store)
//   addr_sel  : controller -> address mux, 0 = PC, 1 = ALU result
//   mem_ready : memory -> controller, current request completes this cycle
// master = controller side, slave = memory side.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (output mem_req, mem_we, addr_sel, input mem_ready);
  modport slave  (input mem_req, mem_we, addr_sel, output mem_ready);
endinterface

// File: rtl/rv_opcode_class.sv
// rv_opcode_class -- pure combinational RV32I opcode classifier.
//   opcode_i  : instr[6:0]
//   class_o   : instruction class (CLS_ILL for anything outside RV32I base)
//   illegal_o : 1 when the opcode is not in the supported set
module rv_opcode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output iclass_e    class_o,
  output logic       illegal_o
);

  always_comb begin
    class_o = CLS_ILL;
    case (opcode_i)
      OP_R:      class_o = CLS_R;
      OP_IMM:    class_o = CLS_I;
      OP_LOAD:   class_o = CLS_LOAD;
      OP_STORE:  class_o = CLS_STORE;
      OP_BRANCH: class_o = CLS_BRANCH;
      OP_JAL:    class_o = CLS_JAL;
      OP_JALR:   class_o = CLS_JALR;
      OP_LUI:    class_o = CLS_LUI;
      OP_AUIPC:  class_o = CLS_AUIPC;
      default:   class_o = CLS_ILL;
    endcase
  end

  assign illegal_o = (class_o == CLS_ILL);

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- RV32I multi-cycle control unit.
// Sequences FETCH/DECODE/EXEC/MEM/WB, handshakes with a wait-state memory,
// counts retired instructions and halts (TRAP) on an illegal opcode.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem             : memory handshake (multicycle_ctrl_if.master)
//   opcode          : IR[6:0], valid from DECODE onward
//   branch_taken    : comparator result, sampled in EXEC
//   ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op,
//   reg_write, wb_sel : datapath controls
//   instr_done      : one-cycle retire pulse
//   instret         : retired-instruction count (wraps)
//   halted          : high while in TRAP
//   state_o         : current state, debug
// Optional feature: define CTRL_TIMEOUT_EN to trap when a memory request
// waits MEM_TIMEOUT cycles without mem_ready.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master mem,
  input  logic [6:0]        opcode,
  input  logic              branch_taken,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic [1:0]        alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        alu_op,
  output logic              reg_write,
  output logic [1:0]        wb_sel,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instret,
  output logic              halted,
  output logic [2:0]        state_o
);

  state_e           state_q, state_d;
  iclass_e          cls_q, dec_cls;
  logic             dec_ill;
  logic [CNT_W-1:0] instret_q;
  ctrl_t            ctrl, ctrl_out;
  logic             tmo;

  rv_opcode_class u_dec (
    .opcode_i  (opcode),
    .class_o   (dec_cls),
    .illegal_o (dec_ill)
  );

`ifdef CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              waiting;

  // Leaving FETCH/MEM only happens on mem_ready, so clearing whenever we are
  // not waiting also covers every state change.
  assign waiting = (state_q == S_FETCH || state_q == S_MEM) && !mem.mem_ready;
  assign tmo     = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || !waiting) wait_q <= '0;
    else                 wait_q <= wait_q + WAIT_W'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CLS_ILL;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
      if (ctrl.instr_done)     instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem.mem_ready) state_d = S_DECODE;
                else if (tmo)      state_d = S_TRAP;
      S_DECODE: state_d = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = S_FETCH;
          CLS_LOAD, CLS_STORE: state_d = S_MEM;
          default:             state_d = S_WB;
        endcase
      end
      S_MEM:    if (mem.mem_ready) state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                else if (tmo)      state_d = S_TRAP;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  // Output decode: Moore on state + latched class; mem_ready only gates the
  // completion strobes of the waiting states, branch_taken only picks pc_src.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req  = 1'b1;
        ctrl.ir_write = mem.mem_ready;
      end
      S_EXEC: begin
        case (cls_q)
          CLS_R: begin
            ctrl.alu_src_a = A_RS1; ctrl.alu_src_b = B_RS2; ctrl.alu_op = ALU_FUNCT;
          end
          CLS_I: begin
            ctrl.alu_src_a = A_RS1; ctrl.alu_src_b = B_IMM; ctrl.alu_op = ALU_FUNCT;
          end
          CLS_LOAD, CLS_STORE, CLS_JALR: begin
            ctrl.alu_src_a = A_RS1; ctrl.alu_src_b = B_IMM; ctrl.alu_op = ALU_ADD;
          end
          CLS_AUIPC: begin
            ctrl.alu_src_a = A_PC;  ctrl.alu_src_b = B_IMM; ctrl.alu_op = ALU_ADD;
          end
          CLS_BRANCH: begin
            ctrl.alu_src_a  = A_RS1; ctrl.alu_src_b = B_RS2; ctrl.alu_op = ALU_BR;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_src     = branch_taken ? PC_BRANCH : PC_PLUS4;
            ctrl.instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_sel = 1'b1;
        ctrl.mem_we   = (cls_q == CLS_STORE);
        if (cls_q == CLS_STORE && mem.mem_ready) begin
          ctrl.pc_write   = 1'b1;
          ctrl.pc_src     = PC_PLUS4;
          ctrl.instr_done = 1'b1;
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        case (cls_q)
          CLS_LOAD: ctrl.wb_sel = WB_MEM;
          CLS_JAL:  begin ctrl.wb_sel = WB_PC4; ctrl.pc_src = PC_JAL;  end
          CLS_JALR: begin ctrl.wb_sel = WB_PC4; ctrl.pc_src = PC_JALR; end
          CLS_LUI:  ctrl.wb_sel = WB_IMM;
          default:  ctrl.wb_sel = WB_ALU;
        endcase
      end
      default: ;
    endcase
  end

  // Everything reads zero while reset is held.
  assign ctrl_out     = rst ? '0 : ctrl;
  assign mem.mem_req  = ctrl_out.mem_req;
  assign mem.mem_we   = ctrl_out.mem_we;
  assign mem.addr_sel = ctrl_out.addr_sel;
  assign ir_write     = ctrl_out.ir_write;
  assign pc_write     = ctrl_out.pc_write;
  assign pc_src       = ctrl_out.pc_src;
  assign alu_src_a    = ctrl_out.alu_src_a;
  assign alu_src_b    = ctrl_out.alu_src_b;
  assign alu_op       = ctrl_out.alu_op;
  assign reg_write    = ctrl_out.reg_write;
  assign wb_sel       = ctrl_out.wb_sel;
  assign instr_done   = ctrl_out.instr_done;
  assign instret      = rst ? '0 : instret_q;
  assign halted       = !rst && (state_q == S_TRAP);
  assign state_o      = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl -- self-checking bench for multicycle_ctrl.
// A per-instruction schedule (cycle-by-cycle expected controls plus the
// mem_ready/branch_taken to drive) is built from the instruction rules and
// replayed against the DUT. CNT_W is kept small so instret wraps often.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             ir_write, pc_write, reg_write, instr_done, halted;
  logic [1:0]       pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_o;

  multicycle_ctrl_if mif ();

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .mem(mif.master), .opcode(opcode),
    .branch_taken(branch_taken), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .instr_done(instr_done), .instret(instret), .halted(halted),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, asel, irw, pcw;
    logic [1:0] pcs, sa, sb, aop;
    logic       rw;
    logic [1:0] wbs;
    logic       done, hlt;
  } obs_t;

  typedef struct {
    logic [6:0] op;
    logic       rdy;
    logic       bt;
    obs_t       e;
  } step_t;

  step_t       q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cnt    = 0;   // model retired count (compared modulo 2^CNT_W)

  function automatic string mnem(input logic [6:0] o);
    case (o)
      7'b0110011: return "R";
      7'b0010011: return "I";
      7'b0000011: return "LD";
      7'b0100011: return "ST";
      7'b1100011: return "BR";
      7'b1101111: return "JAL";
      7'b1100111: return "JALR";
      7'b0110111: return "LUI";
      7'b0010111: return "AUIPC";
      default:    return "ILL";
    endcase
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o;  o.req = mif.mem_req; o.we = mif.mem_we; o.asel = mif.addr_sel;
    o.irw = ir_write; o.pcw = pc_write; o.pcs = pc_src; o.sa = alu_src_a;
    o.sb = alu_src_b; o.aop = alu_op; o.rw = reg_write; o.wbs = wb_sel;
    o.done = instr_done; o.hlt = halted;
    return o;
  endfunction

  task automatic chk_obs(input string tag, input obs_t exp);
    obs_t o;
    o = sample();
    checks++;
    assert (o === exp) else begin
      errors++;
      $error("FAIL %s: controls got %h expected %h", tag, o, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
    logic [CNT_W-1:0] e;
    e = CNT_W'(cnt);
    checks++;
    assert (instret === e) else begin
      errors++;
      $error("FAIL %s_instret: got %0d expected %0d", tag, instret, e);
    end
  endtask

  // A cycle in a given state with all controls idle and don't-care inputs random.
  function automatic step_t idle(input logic [6:0] op, input state_e st);
    step_t s;
    s.op = op; s.rdy = 1'($urandom); s.bt = 1'($urandom);
    s.e = '0; s.e.st = st;
    return s;
  endfunction

  // Expected cycle sequence for one instruction: wf fetch wait states,
  // wm memory wait states, bt branch outcome, ntrap trap cycles to observe.
  task automatic plan(input logic [6:0] op, input int wf, input int wm,
                      input logic bt, input int ntrap);
    step_t s;
    string c;
    c = mnem(op);
    for (int i = 0; i < wf; i++) begin
      s = idle(op, S_FETCH); s.rdy = 1'b0; s.e.req = 1'b1; q.push_back(s);
    end
    s = idle(op, S_FETCH); s.rdy = 1'b1; s.e.req = 1'b1; s.e.irw = 1'b1; q.push_back(s);
    q.push_back(idle(op, S_DECODE));
    if (c == "ILL") begin
      for (int i = 0; i < ntrap; i++) begin
        s = idle(op, S_TRAP); s.e.hlt = 1'b1; q.push_back(s);
      end
      return;
    end
    s = idle(op, S_EXEC);
    case (c)
      "R":     begin s.e.sa = 0; s.e.sb = 0; s.e.aop = 2; end
      "I":     begin s.e.sa = 0; s.e.sb = 1; s.e.aop = 2; end
      "LD", "ST", "JALR": begin s.e.sa = 0; s.e.sb = 1; s.e.aop = 0; end
      "AUIPC": begin s.e.sa = 1; s.e.sb = 1; s.e.aop = 0; end
      "BR":    begin
        s.e.sa = 0; s.e.sb = 0; s.e.aop = 1;
        s.bt = bt; s.e.pcw = 1'b1; s.e.pcs = bt ? 2'd1 : 2'd0; s.e.done = 1'b1;
      end
      default: ;
    endcase
    q.push_back(s);
    if (c == "BR") return;
    if (c == "LD" || c == "ST") begin
      for (int i = 0; i <= wm; i++) begin
        s = idle(op, S_MEM);
        s.rdy = (i == wm); s.e.req = 1'b1; s.e.asel = 1'b1; s.e.we = (c == "ST");
        if (c == "ST" && i == wm) begin s.e.pcw = 1'b1; s.e.done = 1'b1; end
        q.push_back(s);
      end
      if (c == "ST") return;
    end
    s = idle(op, S_WB);
    s.e.rw = 1'b1; s.e.pcw = 1'b1; s.e.done = 1'b1;
    s.e.wbs = (c == "LD") ? 2'd1 : (c == "JAL" || c == "JALR") ? 2'd2 :
              (c == "LUI") ? 2'd3 : 2'd0;
    s.e.pcs = (c == "JAL") ? 2'd2 : (c == "JALR") ? 2'd3 : 2'd0;
    q.push_back(s);
  endtask

  // Replay up to n queued cycles (n < 0: all). Enters and leaves in the low clock phase.
  task automatic run(input string tag, input int n);
    step_t s;
    int k;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      opcode = s.op; mif.mem_ready = s.rdy; branch_taken = s.bt;
      #1;
      chk_obs(tag, s.e);
      chk_cnt(tag);
      if (s.e.done) cnt++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mif.mem_ready = 1'b1; branch_taken = 1'b1; opcode = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    cnt = 0;
    chk_obs("reset", '0);
    chk_cnt("reset");
    rst = 1'b0;
  endtask

  logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] op;
    step_t s;
    mif.mem_ready = 1'b0; branch_taken = 1'b0; opcode = '0; rst = 1'b1;
    @(negedge clk);
    do_reset();

    plan(7'b0010011, 0, 0, 1'b0, 0); run("addi", -1);
    plan(7'b0000011, 0, 3, 1'b0, 0); run("lw_wait", -1);
    plan(7'b1100011, 0, 0, 1'b1, 0); run("beq_taken", -1);
    plan(7'b1100011, 0, 0, 1'b0, 0); run("beq_not", -1);

    // Store interrupted by reset while waiting in MEM.
    plan(7'b0100011, 1, 3, 1'b0, 0); run("sw_pre", 5);
    q.delete();
    rst = 1'b1; mif.mem_ready = 1'b0;
    #1; chk_obs("rst_in_mem", '0);
    @(negedge clk); #1;
    cnt = 0;
    chk_obs("rst_after_edge", '0); chk_cnt("rst_after_edge");
    rst = 1'b0;
    plan(7'b0010011, 0, 0, 1'b0, 0); run("post_rst", -1);

    // Random legal traffic; instret wraps several times at CNT_W=4.
    for (int i = 0; i < 120; i++) begin
      op = legal[$urandom_range(0, 8)];
      plan(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 0);
      run("rand", -1);
    end

    // Illegal opcodes trap and stay trapped until reset.
    plan(7'b0000000, 0, 0, 1'b0, 20); run("trap_zero", -1);
    do_reset();
    plan(7'b0110111, 0, 0, 1'b0, 0); run("after_trap", -1);
    do op = 7'($urandom); while (mnem(op) != "ILL");
    plan(op, $urandom_range(0, 3), 0, 1'b0, 6); run("trap_rand", -1);
    do_reset();

    // Memory never answers in FETCH.
`ifdef CTRL_TIMEOUT_EN
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      s = idle(7'b0010011, S_FETCH); s.rdy = 1'b0; s.e.req = 1'b1; q.push_back(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = idle(7'b0010011, S_TRAP); s.rdy = 1'b0; s.e.hlt = 1'b1; q.push_back(s);
    end
    run("fetch_timeout", -1);
`else
    for (int i = 0; i < 100; i++) begin
      s = idle(7'b0010011, S_FETCH); s.rdy = 1'b0; s.e.req = 1'b1; q.push_back(s);
    end
    run("fetch_stall", -1);
`endif
    do_reset();
    plan(7'b1101111, 0, 0, 1'b0, 0); run("jal_final", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I datapath, succeeding the single-cycle opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and handshakes with a shared instruction/data memory that may insert wait states. It emits per-state datapath controls, counts retired instructions and halts on an illegal opcode. It sits between the IR/opcode field and the datapath muxes, register file, PC register and memory port.

## Interface
- CNT_W, 32: width of retired-instruction counter
- MEM_TIMEOUT, 255: max cycles mem_req may wait for mem_ready (used only with CTRL_TIMEOUT_EN)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from IR (valid from DECODE onward)
- branch_taken  in  1  comparator result from datapath, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write request (store in MEM state)
- addr_sel  out  1  0 = PC, 1 = ALU result drives memory address
- ir_write  out  1  latch fetched word into IR
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = branch target, 2 = JAL target, 3 = JALR target (ALU & ~1)
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = constant 4
- alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded
- reg_write  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = imm (LUI)
- instr_done  out  1  one-cycle pulse when an instruction retires
- instret  out  CNT_W  retired-instruction count
- halted  out  1  sticky; set in TRAP
- state_o  out  3  current state encoding, for debug

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore-decoded from state plus latched opcode class; no output depends combinationally on mem_ready except ir_write/pc_write/instr_done in waiting states.
- FETCH: mem_req=1, addr_sel=0. On mem_ready: ir_write=1, go DECODE. Otherwise stay.
- DECODE: one cycle; class latched from opcode. Legal set: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Any other → TRAP.
- EXEC (one cycle): R: a=rs1,b=rs2,op=10. I-ALU: a=rs1,b=imm,op=10. Load/store/JALR: a=rs1,b=imm,op=00. Branch: a=rs1,b=rs2,op=01. AUIPC: a=PC,b=imm,op=00. LUI/JAL: ALU unused.
- From EXEC: branch → retire in EXEC (pc_write=1, pc_src = branch_taken ? 1 : 0) → FETCH. Load/store → MEM. All others → WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for store. On mem_ready: load → WB; store → retire (pc_write=1, pc_src=0) → FETCH.
- WB (one cycle): reg_write=1; wb_sel: R/I/AUIPC=0, load=1, JAL/JALR=2, LUI=3; pc_write=1, pc_src: JAL=2, JALR=3, else 0 → FETCH.
- Retire: instr_done=1 in the same cycle as the final pc_write; instret += 1, wraps modulo 2^CNT_W.
- TRAP: all control outputs 0, halted=1, remains until rst.

## Timing
- Reset: state=FETCH, instret=0, halted=0. While rst=1 all outputs are 0. First cycle after release, mem_req=1.
- Zero-wait memory CPI: branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5. Each memory wait cycle adds 1.
- mem_req must not drop before mem_ready. mem_ready outside FETCH/MEM is ignored.
- Reset mid-instruction: abandons the instruction with no retire or register write. instret clears in the same edge.
- instret wrap: all-ones + retire → 0, with no other side effect.

## Configuration
- CTRL_TIMEOUT_EN defined: a wait counter runs in FETCH/MEM and clears on mem_ready or state change. When mem_req has been held MEM_TIMEOUT cycles without mem_ready, the next edge enters TRAP (halted=1).
- CTRL_TIMEOUT_EN undefined: no counter; the FSM waits indefinitely. The MEM_TIMEOUT parameter is ignored.

## Structure
- Shared package rv_ctrl_pkg: state enum, opcode localparams, pc_src/alu_src/wb_sel/alu_op encodings, and instruction-class enum.
- One natural sub-module: rv_opcode_class, a pure decode of opcode → class plus an illegal flag, reusable by other controllers.

## Test plan
- ADDI (0010011), mem_ready always 1 → FETCH,DECODE,EXEC,WB; reg_write and instr_done in cycle 4; instret=1.
- LW with mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles with addr_sel=1; wb_sel=1 in WB; total 8 cycles.
- BEQ, branch_taken=1 then a second BEQ with 0 → each retires in EXEC with pc_src=1, then 0; no reg_write.
- Opcode 0000000 → TRAP after DECODE; halted=1 and outputs stay 0 for 20 cycles. Asserting rst restores FETCH with halted=0.
- rst asserted in MEM of an SW → no mem_we after the edge, instret=0, and mem_req reasserted the next cycle.
- With CTRL_TIMEOUT_EN and MEM_TIMEOUT=4, mem_ready held low in FETCH → TRAP entered after the 4th wait cycle. With the macro undefined, the FSM is still in FETCH after 100 cycles.
